// File: rtl/clip_indicator_pkg.sv
// -----------------------------------------------------------------------------
// clip_indicator_pkg
// Shared definitions for the multi-channel clip indicator: the 2-bit display
// mode type and its named values.
// -----------------------------------------------------------------------------
package clip_indicator_pkg;

  typedef enum logic [1:0] {
    MODE_STRETCH     = 2'd0,  // LED follows the hold timer
    MODE_LATCH       = 2'd1,  // LED follows the sticky latch
    MODE_LATCH_BLINK = 2'd2,  // hold timer solid, older clips blink
    MODE_OFF         = 2'd3   // LEDs dark, state keeps running
  } mode_e;

endpackage

// File: rtl/clip_indicator_if.sv
// -----------------------------------------------------------------------------
// clip_indicator_if
// Control/status bundle of the clip indicator.
//   overrange  : per-channel ADC overrange level (master -> slave)
//   mode       : display mode (master -> slave)
//   clear      : one-cycle strobe clearing latches and counters (master -> slave)
//   led        : per-channel LED drive, active high (slave -> master)
//   any_clip   : OR of all led bits (slave -> master)
//   clip_count : packed saturating counters, channel 0 in the LSBs (slave -> master)
// -----------------------------------------------------------------------------
interface clip_indicator_if
  import clip_indicator_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 8
) ();

  logic [NUM_CH-1:0]       overrange;
  mode_e                   mode;
  logic                    clear;
  logic [NUM_CH-1:0]       led;
  logic                    any_clip;
  logic [NUM_CH*CNT_W-1:0] clip_count;

  modport master (
    output overrange, mode, clear,
    input  led, any_clip, clip_count
  );

  modport slave (
    input  overrange, mode, clear,
    output led, any_clip, clip_count
  );

endinterface

// File: rtl/clip_channel.sv
// -----------------------------------------------------------------------------
// clip_channel
// State for one ADC channel: hold timer, sticky latch, registered copy of
// overrange for edge detection, and a saturating rising-edge counter.
//   slow_clock, reset_n : clock, asynchronous active-low reset
//   tick_i              : timer decrement enable
//   overrange_i         : overrange level for this channel
//   clear_i             : clears latch and counter
//   active_o            : hold timer is running
//   latch_o             : a clip was seen since the last clear
//   count_o             : saturating count of overrange rising edges
// -----------------------------------------------------------------------------
module clip_channel #(
  parameter int HOLD_W     = 16,
  parameter int HOLD_TICKS = 20000,
  parameter int CNT_W      = 8
) (
  input  logic             slow_clock,
  input  logic             reset_n,
  input  logic             tick_i,
  input  logic             overrange_i,
  input  logic             clear_i,
  output logic             active_o,
  output logic             latch_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              latch_q, latch_d;
  logic              prev_q;
  logic              rise;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    rise = overrange_i & ~prev_q;

    // Overrange reloads the timer regardless of tick, so a held overrange
    // pins the stretch at its full length.
    hold_d = hold_q;
    if (overrange_i) begin
      hold_d = HOLD_LOAD;
    end else if (tick_i && (hold_q != '0)) begin
      hold_d = hold_q - HOLD_W'(1);
    end

    // A clip in the same cycle as clear wins, so no event is lost.
    latch_d = overrange_i | (latch_q & ~clear_i);

    // Clear coinciding with a new edge leaves that edge counted.
    if (clear_i) begin
      cnt_d = rise ? CNT_W'(1) : '0;
    end else if (rise) begin
      cnt_d = sat_inc(cnt_q);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge slow_clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_q  <= '0;
      latch_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      hold_q  <= hold_d;
      latch_q <= latch_d;
      prev_q  <= overrange_i;
      cnt_q   <= cnt_d;
    end
  end

  assign active_o = (hold_q != '0);
  assign latch_o  = latch_q;
  assign count_o  = cnt_q;

endmodule

// File: rtl/clip_indicator.sv
// -----------------------------------------------------------------------------
// clip_indicator
// Multi-channel ADC clip LED driver. Shared tick and blink generators feed
// NUM_CH clip_channel instances; the display mode selects what each LED shows.
//   slow_clock : sole clock
//   reset_n    : asynchronous active-low reset
//   bus        : clip_indicator_if slave (overrange, mode, clear in;
//                led, any_clip, clip_count out)
// Outputs are decoded only from registers and mode, never directly from
// overrange or clear.
// -----------------------------------------------------------------------------
module clip_indicator
  import clip_indicator_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int HOLD_W      = 16,
  parameter int HOLD_TICKS  = 20000,
  parameter int PRESCALE    = 1,
  parameter int BLINK_TICKS = 5000,
  parameter int CNT_W       = 8
) (
  input logic             slow_clock,
  input logic             reset_n,
  clip_indicator_if.slave bus
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BL_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_TICKS - 1);

  logic [PS_W-1:0]         ps_q, ps_d;
  logic [BL_W-1:0]         bl_q, bl_d;
  logic                    blink_q, blink_d;
  logic                    tick;
  logic [NUM_CH-1:0]       active;
  logic [NUM_CH-1:0]       latched;
  logic [NUM_CH*CNT_W-1:0] counts;
  logic [NUM_CH-1:0]       led;

  // With PRESCALE=1 the counter sits at 0 == PS_LAST, so tick stays high.
  always_comb begin
    tick    = (ps_q == PS_LAST);
    ps_d    = tick ? '0 : ps_q + PS_W'(1);
    bl_d    = bl_q;
    blink_d = blink_q;
    if (tick) begin
      if (bl_q == BL_LAST) begin
        bl_d    = '0;
        blink_d = ~blink_q;
      end else begin
        bl_d    = bl_q + BL_W'(1);
      end
    end
  end

  always_ff @(posedge slow_clock or negedge reset_n) begin
    if (!reset_n) begin
      ps_q    <= '0;
      bl_q    <= '0;
      blink_q <= 1'b0;
    end else begin
      ps_q    <= ps_d;
      bl_q    <= bl_d;
      blink_q <= blink_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clip_channel #(
      .HOLD_W     (HOLD_W),
      .HOLD_TICKS (HOLD_TICKS),
      .CNT_W      (CNT_W)
    ) u_ch (
      .slow_clock  (slow_clock),
      .reset_n     (reset_n),
      .tick_i      (tick),
      .overrange_i (bus.overrange[g]),
      .clear_i     (bus.clear),
      .active_o    (active[g]),
      .latch_o     (latched[g]),
      .count_o     (counts[g*CNT_W +: CNT_W])
    );
  end

  // Blink shows latched history only in the low half of the blink period;
  // a running hold timer always overrides it with a solid LED.
  always_comb begin
    led = '0;
    case (bus.mode)
      MODE_STRETCH:     led = active;
      MODE_LATCH:       led = latched;
      MODE_LATCH_BLINK: led = active | (latched & {NUM_CH{~blink_q}});
      MODE_OFF:         led = '0;
      default:          led = '0;
    endcase
  end

  assign bus.led        = led;
  assign bus.any_clip   = |led;
  assign bus.clip_count = counts;

endmodule
